// File: rtl/smart_led_pkg.sv
// Shared types, field layout and word packing for the smart-LED frame transmitter.
// Optional macro SMART_LED_TX_PARITY_EN: bit31 carries even parity over the word.
package smart_led_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      START,
      WORD,
      GAP
   } state_e;

   localparam int unsigned WORD_BITS  = 32;
   localparam int unsigned COLOR_BITS = 10;
   localparam int unsigned CMD        = 0;
   localparam int unsigned RED_LSB    = 1;
   localparam int unsigned GREEN_LSB  = 11;
   localparam int unsigned BLUE_LSB   = 21;
   localparam int unsigned PARITY     = 31;

   function automatic logic [WORD_BITS-1:0] pack_word(
      input logic [COLOR_BITS-1:0] red,
      input logic [COLOR_BITS-1:0] green,
      input logic [COLOR_BITS-1:0] blue
   );
      logic [WORD_BITS-1:0] w;
      w                          = '0;
      w[CMD]                     = 1'b1;
      w[RED_LSB   +: COLOR_BITS] = red;
      w[GREEN_LSB +: COLOR_BITS] = green;
      w[BLUE_LSB  +: COLOR_BITS] = blue;
`ifdef SMART_LED_TX_PARITY_EN
      w[PARITY]                  = ^w[PARITY-1:0];
`else
      w[PARITY]                  = 1'b0;
`endif
      return w;
   endfunction

endpackage

// File: rtl/smart_led_frame_tx_manchester_symbol.sv
// Half-bit timer and registered Manchester symbol output.
// dout is computed from next-cycle drive/bit so the line tracks the FSM without lag.
module smart_led_manchester_symbol #(
   parameter int unsigned HALF_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic drive_i,
   input  logic bit_i,
   output logic dout_o,
   output logic half_end_o,
   output logic bit_end_o
);
   import smart_led_pkg::*;

   localparam int unsigned TW = $clog2(HALF_CYCLES);

   logic [TW-1:0] timer_q, timer_d;
   logic          half_q, half_d;
   logic          dout_q, dout_d;

   always_comb begin
      half_end_o = run_i && (timer_q == TW'(HALF_CYCLES - 1));
      bit_end_o  = half_end_o && half_q;
      timer_d    = timer_q;
      half_d     = half_q;
      if (run_i) begin
         if (half_end_o) begin
            timer_d = '0;
            half_d  = ~half_q;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
      // '0' is high-then-low, '1' is low-then-high
      dout_d = drive_i && (half_d ? bit_i : ~bit_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q <= '0;
         half_q  <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         half_q  <= half_d;
         dout_q  <= dout_d;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/smart_led_frame_tx.sv
// Smart-LED frame transmitter: holding register, shift register and frame FSM.
// Optional macro SMART_LED_TX_PARITY_EN enables the parity bit in packed words.
module smart_led_frame_tx #(
   parameter int unsigned HALF_CYCLES   = 16,
   parameter int unsigned PREAMBLE_BITS = 8,
   parameter int unsigned GAP_BITS      = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [9:0] s_red,
   input  logic [9:0] s_green,
   input  logic [9:0] s_blue,
   input  logic       s_last,
   output logic       dout,
   output logic       dout_oe,
   output logic       busy,
   output logic       underrun
);
   import smart_led_pkg::*;

   state_e               state_q, state_d;
   logic [7:0]           bit_cnt_q, bit_cnt_d;
   logic [4:0]           wbit_q, wbit_d;
   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic                 cur_last_q, cur_last_d;
   logic [WORD_BITS-1:0] hold_word_q, hold_word_d;
   logic                 hold_last_q, hold_last_d;
   logic                 hold_full_q, hold_full_d;
   logic                 underrun_q, underrun_d;
   logic                 oe_q, oe_d;
   logic                 load, accept;
   logic                 line_bit, drive;
   logic                 sym_half_end, sym_bit_end, bit_end;

   assign bit_end = sym_half_end && sym_bit_end;
   assign accept  = s_valid && !hold_full_q;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      wbit_d     = wbit_q;
      shift_d    = shift_q;
      cur_last_d = cur_last_q;
      load       = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         IDLE:     if (hold_full_q) state_d = PREAMBLE;
         PREAMBLE: if (bit_end) begin
            if (bit_cnt_q == 8'(PREAMBLE_BITS - 1)) begin
               state_d   = START;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 8'd1;
            end
         end
         START:    if (bit_end) begin
            load    = 1'b1;
            state_d = WORD;
         end
         WORD:     if (bit_end) begin
            if (wbit_q == 5'd31) begin
               wbit_d = '0;
               if (cur_last_q) begin
                  state_d = GAP;
               end else if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = GAP;
               end
            end else begin
               wbit_d  = wbit_q + 5'd1;
               shift_d = shift_q >> 1;
            end
         end
         GAP:      if (bit_end) begin
            if (bit_cnt_q == 8'(GAP_BITS - 1)) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 8'd1;
            end
         end
         default:  state_d = IDLE;
      endcase
      if (load) begin
         shift_d    = hold_word_q;
         cur_last_d = hold_last_q;
      end

      hold_full_d = (hold_full_q && !load) || accept;
      hold_word_d = hold_word_q;
      hold_last_d = hold_last_q;
      if (accept) begin
         hold_word_d = pack_word(s_red, s_green, s_blue);
         hold_last_d = s_last;
      end

      // Line bit for the coming cycle, taken from next state/shift value
      drive    = (state_d == PREAMBLE) || (state_d == START) || (state_d == WORD);
      line_bit = (state_d == START) || ((state_d == WORD) && shift_d[0]);
      oe_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         wbit_q      <= '0;
         shift_q     <= '0;
         cur_last_q  <= 1'b0;
         hold_word_q <= '0;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         underrun_q  <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wbit_q      <= wbit_d;
         shift_q     <= shift_d;
         cur_last_q  <= cur_last_d;
         hold_word_q <= hold_word_d;
         hold_last_q <= hold_last_d;
         hold_full_q <= hold_full_d;
         underrun_q  <= underrun_d;
         oe_q        <= oe_d;
      end
   end

   smart_led_manchester_symbol #(
      .HALF_CYCLES (HALF_CYCLES)
   ) u_symbol (
      .clk_i      (clk),
      .rst_i      (rst),
      .run_i      (state_q != IDLE),
      .drive_i    (drive),
      .bit_i      (line_bit),
      .dout_o     (dout),
      .half_end_o (sym_half_end),
      .bit_end_o  (sym_bit_end)
   );

   assign s_ready  = !hold_full_q;
   assign dout_oe  = oe_q;
   assign busy     = (state_q != IDLE);
   assign underrun = underrun_q;

endmodule
